led_status_gen: RTL and testbench
=================================

// Module: led_status_gen
// PURPOSE
//  Upstream feeder for the port LED driver, so the driver needs no logic of its own.
//  Produces four signals for the driver from PCS/MAC status:
//   - has_link: debounced from the PCS block_lock.
//   - on_frame_sent / on_frame_received: link-qualified 1-cycle pulses.
//   - blink: free-running square wave that times the activity flicker.
//  One instance per 40GbE port, in the MAC user-clock domain.
// PARAMETERS
//  BLINK_HALF_PERIOD  15625000  clk cycles per blink half-period (100 ms @156.25 MHz); >=2
//  LINK_UP_CYCLES     1562500   consecutive synced-lock cycles to declare link up; >=1
//  LINK_DOWN_CYCLES   156250    consecutive synced-no-lock cycles to declare link down; >=1
// PORTS
//  clk                in   1  user clock; all logic on rising edge
//  rst_n              in   1  asynchronous, active-low reset
//  block_lock         in   1  raw PCS block lock; may be asynchronous to clk
//  tx_frame_done      in   1  1-cycle pulse: MAC finished transmitting a frame
//  rx_frame_done      in   1  1-cycle pulse: MAC accepted a received frame
//  has_link           out  1  debounced link status
//  on_frame_sent      out  1  1-cycle pulse, tx activity
//  on_frame_received  out  1  1-cycle pulse, rx activity
//  blink              out  1  square wave, period 2*BLINK_HALF_PERIOD
// BEHAVIOUR
//  Reset (rst_n=0, async):
//   - has_link, on_frame_sent, on_frame_received and blink all =0.
//   - Sync flops =0, all counters =0, FSM=DOWN.
//   - Assertion mid-operation aborts any debounce immediately; nothing is retained.
//  Lock synchronizer: block_lock -> 2 flops -> lock_s.
//  Link FSM (has_link is registered, 1 iff state==UP):
//   - DOWN: lock_s=1 -> dcnt+1; lock_s=0 -> dcnt=0.
//     lock_s=1 and dcnt==LINK_UP_CYCLES-1 -> UP, dcnt=0.
//   - UP: lock_s=0 -> dcnt+1; lock_s=1 -> dcnt=0.
//     lock_s=0 and dcnt==LINK_DOWN_CYCLES-1 -> DOWN, dcnt=0.
//   - Net latency: has_link rises exactly LINK_UP_CYCLES+1 edges after the first edge
//     that samples block_lock=1, provided block_lock holds 1 throughout.
//     Falling edge is symmetric with LINK_DOWN_CYCLES.
//   - Any glitch shorter than the threshold restarts the count from 0.
//   - dcnt width = $clog2(max(LINK_UP_CYCLES,LINK_DOWN_CYCLES)+1); never wraps.
//  Activity pulses:
//   - Registered: on_frame_sent <= tx_frame_done & has_link
//     (value of has_link before this edge). Likewise rx -> on_frame_received.
//   - 1-cycle latency; tx and rx are fully independent; simultaneous events give
//     simultaneous pulses.
//   - Back-to-back input pulses give back-to-back output pulses; no merging, no stretching.
//   - Events while has_link=0 are dropped.
//  Blink generator:
//   - bcnt counts 0..BLINK_HALF_PERIOD-1, then wraps to 0; blink toggles on the wrap edge.
//   - Free-running, independent of link state.
//   - First blink rise is on the BLINK_HALF_PERIOD-th edge after reset release.
//   - Duty cycle exactly 50%.
//  No combinational path from any input to any output.
// TESTING (override BLINK_HALF_PERIOD=4, LINK_UP_CYCLES=5, LINK_DOWN_CYCLES=3)
//  1. Release reset, hold inputs 0 -> all outputs 0; blink rises after edge 4,
//     falls after edge 8, and keeps period 8.
//  2. block_lock=1 from edge 0 -> has_link=0 through edge 5, =1 after edge 6; stays 1.
//  3. Link up, block_lock=0 for 2 cycles then 1 -> has_link stays 1.
//     block_lock=0 held -> has_link=0 exactly 4 edges after the first low sample.
//  4. Link up, tx_frame_done and rx_frame_done pulsed together, then tx for 3
//     consecutive cycles -> one simultaneous pulse pair one cycle later,
//     then 3 consecutive on_frame_sent pulses.
//  5. Link down, pulse tx/rx_frame_done -> on_frame_sent and on_frame_received stay 0.
//  6. Assert rst_n=0 asynchronously, mid-debounce (dcnt=3) and with blink=1 ->
//     all outputs 0 immediately; after release the full LINK_UP_CYCLES+1 edges are
//     required again.

Source files
------------

// File: rtl/led_status_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : led_status_gen_if
// Brief    : Status bundle between the PCS/MAC side and led_status_gen.
// Revision : 1.0 - initial release
// ============================================================================
interface led_status_gen_if;
    logic block_lock;
    logic tx_frame_done;
    logic rx_frame_done;
    logic has_link;
    logic on_frame_sent;
    logic on_frame_received;
    logic blink;

    // master: the PCS/MAC side that raises status and consumes LED drive
    modport master (
        output block_lock,
        output tx_frame_done,
        output rx_frame_done,
        input  has_link,
        input  on_frame_sent,
        input  on_frame_received,
        input  blink
    );

    modport slave (
        input  block_lock,
        input  tx_frame_done,
        input  rx_frame_done,
        output has_link,
        output on_frame_sent,
        output on_frame_received,
        output blink
    );
endinterface
`default_nettype wire

// File: rtl/led_status_gen.sv
`default_nettype none
// ============================================================================
// Module   : led_status_gen
// Brief    : Debounced link status, link-qualified activity pulses and a
//            free-running blink square wave for the port LED driver.
// Revision : 1.0 - initial release
// ============================================================================
module led_status_gen #(
    parameter int BLINK_HALF_PERIOD = 15625000,
    parameter int LINK_UP_CYCLES    = 1562500,
    parameter int LINK_DOWN_CYCLES  = 156250
) (
    input  logic             clk,
    input  logic             rst_n,
    led_status_gen_if.slave  bus
);

    localparam int c_DCNT_MAX = (LINK_UP_CYCLES > LINK_DOWN_CYCLES) ?
                                LINK_UP_CYCLES : LINK_DOWN_CYCLES;
    localparam int c_DW       = $clog2(c_DCNT_MAX + 1);
    localparam int c_BW       = $clog2(BLINK_HALF_PERIOD);

    localparam logic [c_DW-1:0] c_UP_LAST   = c_DW'(LINK_UP_CYCLES - 1);
    localparam logic [c_DW-1:0] c_DOWN_LAST = c_DW'(LINK_DOWN_CYCLES - 1);
    localparam logic [c_BW-1:0] c_BLK_LAST  = c_BW'(BLINK_HALF_PERIOD - 1);

    typedef enum logic [0:0] {
        ST_DOWN = 1'b0,
        ST_UP   = 1'b1
    } link_state_t;

    logic             r_sync1_q;
    logic             r_lock_s_q;
    link_state_t      r_state_q,    w_state_d;
    logic [c_DW-1:0]  r_dcnt_q,     w_dcnt_d;
    logic             r_has_link_q, w_has_link_d;
    logic             r_sent_q,     w_sent_d;
    logic             r_rcvd_q,     w_rcvd_d;
    logic [c_BW-1:0]  r_bcnt_q,     w_bcnt_d;
    logic             r_blink_q,    w_blink_d;

    // Link debounce: dcnt counts consecutive samples that disagree with the
    // current state; any agreeing sample restarts the count.
    always_comb begin
        w_state_d = r_state_q;
        w_dcnt_d  = r_dcnt_q;
        case (r_state_q)
            ST_DOWN: begin
                if (r_lock_s_q) begin
                    if (r_dcnt_q == c_UP_LAST) begin
                        w_state_d = ST_UP;
                        w_dcnt_d  = '0;
                    end else begin
                        w_dcnt_d  = r_dcnt_q + c_DW'(1);
                    end
                end else begin
                    w_dcnt_d = '0;
                end
            end
            ST_UP: begin
                if (!r_lock_s_q) begin
                    if (r_dcnt_q == c_DOWN_LAST) begin
                        w_state_d = ST_DOWN;
                        w_dcnt_d  = '0;
                    end else begin
                        w_dcnt_d  = r_dcnt_q + c_DW'(1);
                    end
                end else begin
                    w_dcnt_d = '0;
                end
            end
            default: begin
                w_state_d = ST_DOWN;
                w_dcnt_d  = '0;
            end
        endcase
        w_has_link_d = (w_state_d == ST_UP);
    end

    // Activity is qualified with the link status as it stood before this edge.
    always_comb begin
        w_sent_d = bus.tx_frame_done & r_has_link_q;
        w_rcvd_d = bus.rx_frame_done & r_has_link_q;
    end

    always_comb begin
        w_bcnt_d  = r_bcnt_q + c_BW'(1);
        w_blink_d = r_blink_q;
        if (r_bcnt_q == c_BLK_LAST) begin
            w_bcnt_d  = '0;
            w_blink_d = ~r_blink_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1_q    <= 1'b0;
            r_lock_s_q   <= 1'b0;
            r_state_q    <= ST_DOWN;
            r_dcnt_q     <= '0;
            r_has_link_q <= 1'b0;
            r_sent_q     <= 1'b0;
            r_rcvd_q     <= 1'b0;
            r_bcnt_q     <= '0;
            r_blink_q    <= 1'b0;
        end else begin
            r_sync1_q    <= bus.block_lock;
            r_lock_s_q   <= r_sync1_q;
            r_state_q    <= w_state_d;
            r_dcnt_q     <= w_dcnt_d;
            r_has_link_q <= w_has_link_d;
            r_sent_q     <= w_sent_d;
            r_rcvd_q     <= w_rcvd_d;
            r_bcnt_q     <= w_bcnt_d;
            r_blink_q    <= w_blink_d;
        end
    end

    assign bus.has_link          = r_has_link_q;
    assign bus.on_frame_sent     = r_sent_q;
    assign bus.on_frame_received = r_rcvd_q;
    assign bus.blink             = r_blink_q;

endmodule
`default_nettype wire

// File: tb/tb_led_status_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_status_gen
// Brief    : Scoreboard bench for led_status_gen with a history-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_status_gen;

    localparam int H  = 4;
    localparam int LU = 5;
    localparam int LD = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    led_status_gen_if bus();

    led_status_gen #(
        .BLINK_HALF_PERIOD (H),
        .LINK_UP_CYCLES    (LU),
        .LINK_DOWN_CYCLES  (LD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // expectation order: {has_link, on_frame_sent, on_frame_received, blink}
    logic [3:0] exp_q[$];
    int         vectors     = 0;
    int         miscompares = 0;

    // Reference model: edge count since reset release, raw samples per edge,
    // current link state and the edge of the last link change.
    int  m_n;
    bit  m_samp[$];
    bit  m_link;
    int  m_last_flip;

    function automatic void model_reset();
        m_n         = 0;
        m_samp      = {};
        m_link      = 1'b0;
        m_last_flip = 0;
    endfunction

    // The debouncer at edge n sees the raw sample taken at edge n-2.
    function automatic bit seen_at(int e);
        if (e < 3) return 1'b0;
        return m_samp[e - 3];
    endfunction

    function automatic logic [3:0] model_edge(bit lk, bit tx, bit rx);
        bit prev_link;
        int thr;
        bit all_opp;
        m_n = m_n + 1;
        m_samp.push_back(lk);
        prev_link = m_link;
        thr = m_link ? LD : LU;
        if (m_n - m_last_flip >= thr) begin
            all_opp = 1'b1;
            for (int j = m_n - thr + 1; j <= m_n; j++)
                if (seen_at(j) == m_link) all_opp = 1'b0;
            if (all_opp) begin
                m_link      = !m_link;
                m_last_flip = m_n;
            end
        end
        return {m_link, tx & prev_link, rx & prev_link, ((m_n / H) % 2) == 1};
    endfunction

    task automatic step(input bit lk, input bit tx, input bit rx,
                        input bit do_rst, input bit do_rel);
        bit rst_was;
        @(posedge clk);
        #1;
        rst_was = rst_n;
        if (do_rst) begin
            rst_n = 1'b0;
            model_reset();
            exp_q.push_back(4'b0000);
        end else if (!rst_was) begin
            exp_q.push_back(4'b0000);
        end else begin
            exp_q.push_back(model_edge(bus.block_lock, bus.tx_frame_done,
                                       bus.rx_frame_done));
        end
        if (do_rel) rst_n = 1'b1;
        bus.block_lock    = lk;
        bus.tx_frame_done = tx;
        bus.rx_frame_done = rx;
    endtask

    task automatic hold(input int cycles, input bit lk);
        for (int k = 0; k < cycles; k++) step(lk, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin : monitor
        logic [3:0] exp_v;
        logic [3:0] act_v;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                exp_v = exp_q.pop_front();
                act_v = {bus.has_link, bus.on_frame_sent,
                         bus.on_frame_received, bus.blink};
                vectors++;
                if (act_v !== exp_v) begin
                    miscompares++;
                    $display("FAIL outputs vec %0d t=%0t: got link/sent/rcvd/blink=%b expected %b",
                             vectors, $time, act_v, exp_v);
                end
            end
        end
    end

    initial begin : stimulus
        bit lk;
        int run;
        bus.block_lock    = 1'b0;
        bus.tx_frame_done = 1'b0;
        bus.rx_frame_done = 1'b0;
        model_reset();

        // reset state, release, idle: blink period only
        hold(3, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        hold(20, 1'b0);

        // link up, short dropout ignored, long dropout takes link down
        hold(12, 1'b1);
        hold(2, 1'b0);
        hold(6, 1'b1);
        hold(6, 1'b0);

        // link up, paired pulse then three back-to-back tx pulses
        hold(9, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        hold(3, 1'b1);

        // link down: activity must be dropped
        hold(7, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        hold(2, 1'b0);

        // asynchronous reset mid-debounce, then a full debounce again
        hold(5, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        hold(12, 1'b1);

        // randomized lock runs, activity and occasional resets
        lk  = 1'b0;
        run = 0;
        for (int i = 0; i < 1500; i++) begin
            if (run == 0) begin
                lk  = 1'($urandom_range(0, 1));
                run = $urandom_range(1, 9);
            end
            run--;
            if ($urandom_range(0, 299) == 0) begin
                step(lk, 1'b0, 1'b0, 1'b1, 1'b0);
                step(lk, 1'b0, 1'b0, 1'b0, 1'b0);
                step(lk, 1'b0, 1'b0, 1'b0, 1'b1);
            end else begin
                step(lk, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'b0, 1'b0);
            end
        end

        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
